// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: formats store data and byte enables, extends load data,
// drives the data-memory request/response bus and stalls the pipeline until the access completes.
module mem_stage_lsu #(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [size-1:0] ALU_out_MEM_in,
  input  logic [size-1:0] data2_MEM_in,
  input  logic            DMemWR_MEM_in,
  input  logic            mem_rd_en_MEM_in,
  input  logic [1:0]      store_size_MEM_in,
  input  logic [2:0]      load_size_MEM_in,
  input  logic            hold_in,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [size-1:0] dmem_addr,
  output logic [size-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [size-1:0] dmem_rdata,
  output logic [size-1:0] load_data_MEM_out,
  output logic            lsu_stall,
  output logic            misalign_exc,
  output logic [1:0]      o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [1:0]      r_lane_q;
  logic [2:0]      r_size_q;
  logic [size-1:0] r_data_q;

  logic            w_store;
  logic            w_load_legal;
  logic            w_load;
  logic            w_op_valid;
  logic [1:0]      w_acc_size;
  logic            w_misalign;
  logic            w_go;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [size-1:0] w_rdata_fmt;

  // Handshake: dmem_req/dmem_gnt form a valid/ready pair; a transfer happens on a
  // clock edge where both are high. dmem_rvalid is honoured only in WAIT.

  always_comb begin
    w_load_legal = 1'b0;
    case (load_size_MEM_in)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_load_legal = 1'b1;
      default:                                w_load_legal = 1'b0;
    endcase
  end

  assign w_store    = DMemWR_MEM_in && (store_size_MEM_in != 2'b11);
  assign w_load     = mem_rd_en_MEM_in && w_load_legal;
  assign w_op_valid = w_store || w_load;
  // Store wins when both are requested, so its size governs alignment.
  assign w_acc_size = w_store ? store_size_MEM_in : load_size_MEM_in[1:0];
  assign w_misalign = ((w_acc_size == 2'b01) && ALU_out_MEM_in[0]) ||
                      ((w_acc_size == 2'b10) && (ALU_out_MEM_in[1:0] != 2'b00));
  assign w_go       = (r_state == IDLE) && w_op_valid && !w_misalign;

  always_comb begin
    w_byte = 8'h00;
    case (r_lane_q)
      2'd0: w_byte = dmem_rdata[7:0];
      2'd1: w_byte = dmem_rdata[15:8];
      2'd2: w_byte = dmem_rdata[23:16];
      2'd3: w_byte = dmem_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = r_lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    w_rdata_fmt = '0;
    case (r_size_q)
      3'b000:  w_rdata_fmt = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_rdata_fmt = {{16{w_half[15]}}, w_half};
      3'b010:  w_rdata_fmt = dmem_rdata;
      3'b100:  w_rdata_fmt = {24'h000000, w_byte};
      3'b101:  w_rdata_fmt = {16'h0000, w_half};
      default: w_rdata_fmt = '0;
    endcase
  end

  always_comb begin
    dmem_req          = 1'b0;
    dmem_we           = 1'b0;
    dmem_addr         = '0;
    dmem_wdata        = '0;
    dmem_be           = 4'b0000;
    load_data_MEM_out = '0;
    lsu_stall         = 1'b0;
    misalign_exc      = 1'b0;
    if (reset) begin
      dmem_addr = {ALU_out_MEM_in[size-1:2], 2'b00};
      case (r_state)
        IDLE: begin
          if (w_op_valid && w_misalign) begin
            misalign_exc = 1'b1;
          end else if (w_go) begin
            dmem_req  = 1'b1;
            dmem_we   = w_store;
            lsu_stall = !(w_store && dmem_gnt);
            if (w_store) begin
              case (store_size_MEM_in)
                2'b00: begin
                  dmem_wdata = {4{data2_MEM_in[7:0]}};
                  dmem_be    = 4'b0001 << ALU_out_MEM_in[1:0];
                end
                2'b01: begin
                  dmem_wdata = {2{data2_MEM_in[15:0]}};
                  dmem_be    = ALU_out_MEM_in[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                  dmem_wdata = data2_MEM_in;
                  dmem_be    = 4'b1111;
                end
              endcase
            end
          end
        end
        WAIT: begin
          lsu_stall = !dmem_rvalid;
          if (dmem_rvalid) load_data_MEM_out = w_rdata_fmt;
        end
        DONE: load_data_MEM_out = r_data_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_lane_q <= 2'd0;
      r_size_q <= 3'd0;
      r_data_q <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_go && dmem_gnt) begin
            if (w_store) begin
              r_data_q <= '0;
              if (hold_in) r_state <= DONE;
            end else begin
              r_lane_q <= ALU_out_MEM_in[1:0];
              r_size_q <= load_size_MEM_in;
              r_state  <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dmem_rvalid) begin
            r_data_q <= w_rdata_fmt;
            r_state  <= hold_in ? DONE : IDLE;
          end
        end
        DONE: begin
          // The access already happened; just wait for the pipeline to move on.
          if (!hold_in) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_dbg_state = r_state;

endmodule
